// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall producer: FSM state type and register index width.
package hazard_stall_unit_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      TOUT = 2'd2
   } hazard_fsm_e;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-control bundle between the core/bus side (master) and hazard_stall_unit (slave).
interface hazard_stall_unit_if
   import hazard_stall_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = REG_ADDR_W
);
   logic [ADDR_W-1:0] id_rs1;
   logic [ADDR_W-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [ADDR_W-1:0] exe_rd;
   logic              exe_mem_read;
   logic              exe_pc_sel;
   logic              imem_req;
   logic              imem_ack;
   logic              dmem_req;
   logic              dmem_ack;
   logic              load_hazard;
   logic              branch_hazard;
   logic              stall_pipl;
   logic              bus_timeout;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, exe_rd, exe_mem_read, exe_pc_sel,
      output imem_req, imem_ack, dmem_req, dmem_ack,
      input  load_hazard, branch_hazard, stall_pipl, bus_timeout
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, exe_rd, exe_mem_read, exe_pc_sel,
      input  imem_req, imem_ack, dmem_req, dmem_ack,
      output load_hazard, branch_hazard, stall_pipl, bus_timeout
   );

endinterface

// File: rtl/hazard_stall_unit_perf_counter.sv
// Saturating event counter with enable and synchronous clear; holds at all-ones.
module hazard_perf_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / taken-branch hazard detection plus bus-wait stall with timeout release.
// Optional performance counters are built when STALL_PERF_CNT_EN is defined.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
`ifdef STALL_PERF_CNT_EN
   ,
   parameter int unsigned PERF_CNT_W     = 32
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   hazard_stall_unit_if.slave    bus
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [PERF_CNT_W-1:0] perf_stall_cnt,
   output logic [PERF_CNT_W-1:0] perf_load_cnt,
   output logic [PERF_CNT_W-1:0] perf_flush_cnt
`endif
);

   localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   hazard_fsm_e     state;
   logic [CntW-1:0] wait_cnt;
   logic            bus_timeout_q;
   logic            wait_raw;
   logic            use_match;
   logic            stall;
   logic            branch;
   logic            load;

   assign wait_raw = (bus.imem_req & ~bus.imem_ack) | (bus.dmem_req & ~bus.dmem_ack);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= RUN;
         wait_cnt      <= '0;
         bus_timeout_q <= 1'b0;
      end else begin
         bus_timeout_q <= 1'b0;
         unique case (state)
            RUN: begin
               if (wait_raw) begin
                  state    <= WAIT;
                  wait_cnt <= CntW'(1);
               end
            end
            WAIT: begin
               if (!wait_raw) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == CntLast) begin
                  state         <= TOUT;
                  bus_timeout_q <= 1'b1;
               end else if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + CntW'(1);
               end
            end
            TOUT: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   // The timeout cycle drops the stall so the pipeline can advance past the hung access.
   assign stall     = wait_raw & (state != TOUT) & ~reset;
   assign branch    = bus.exe_pc_sel & ~stall & ~reset;
   assign use_match = (bus.id_use_rs1 & (bus.id_rs1 == bus.exe_rd)) |
                      (bus.id_use_rs2 & (bus.id_rs2 == bus.exe_rd));
   assign load      = bus.exe_mem_read & (bus.exe_rd != '0) & use_match &
                      ~branch & ~stall & ~reset;

   assign bus.stall_pipl    = stall;
   assign bus.branch_hazard = branch;
   assign bus.load_hazard   = load;
   assign bus.bus_timeout   = bus_timeout_q & ~reset;

`ifdef STALL_PERF_CNT_EN
   hazard_perf_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (reset),
      .en    (stall),
      .count (perf_stall_cnt)
   );

   hazard_perf_counter #(.WIDTH(PERF_CNT_W)) u_load_cnt (
      .clk   (clk),
      .clear (reset),
      .en    (load),
      .count (perf_load_cnt)
   );

   hazard_perf_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clear (reset),
      .en    (branch),
      .count (perf_flush_cnt)
   );
`endif

endmodule
